// File: rtl/gecko_writeback_tracker.sv
// Retirement end of the Gecko register-status protocol: arbitrates completed results onto
// the single register-file write port and retires the per-register pending counters.
module gecko_writeback_tracker #(
    parameter int NUM_SOURCES   = 3,
    parameter int COUNTER_WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          issue_valid,
    input  logic [4:0]                    issue_rd,
    input  logic [NUM_SOURCES-1:0]        src_valid,
    output logic [NUM_SOURCES-1:0]        src_ready,
    input  logic [NUM_SOURCES*5-1:0]      src_reg_addr,
    input  logic [NUM_SOURCES*32-1:0]     src_value,
    output logic                          rf_write_enable,
    output logic [4:0]                    rf_write_addr,
    output logic [31:0]                   rf_write_value,
    output logic [32*COUNTER_WIDTH-1:0]   reg_counters,
    output logic                          retire_valid,
    output logic [4:0]                    retire_addr,
    output logic                          error
);

    localparam int PTR_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

    logic [PTR_W-1:0]         ptr;
    logic [PTR_W-1:0]         cand_idx;
    logic [PTR_W-1:0]         grant_idx;
    logic [NUM_SOURCES-1:0]   grant;
    logic                     grant_any;
    logic [4:0]               g_addr;
    logic [31:0]              g_value;
    logic                     inc_hit;
    logic                     dec_hit;
    logic                     same_reg;
    logic [COUNTER_WIDTH-1:0] cnt [32];

    // Round-robin search beginning at ptr; nothing is granted while reset is held.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            cand_idx = PTR_W'((int'(ptr) + k) % NUM_SOURCES);
            if (!grant_any && !rst && src_valid[cand_idx]) begin
                grant_any       = 1'b1;
                grant_idx       = cand_idx;
                grant[cand_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        g_addr  = '0;
        g_value = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (grant[i]) begin
                g_addr  = src_reg_addr[i*5 +: 5];
                g_value = src_value[i*32 +: 32];
            end
        end
    end

    assign src_ready = grant;
    assign inc_hit   = issue_valid && (issue_rd != 5'd0);
    assign dec_hit   = grant_any && (g_addr != 5'd0);
    assign same_reg  = inc_hit && dec_hit && (issue_rd == g_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= (int'(grant_idx) == NUM_SOURCES - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    // Write port and retire pulse share the same one-cycle-late timing.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_write_enable <= 1'b0;
            rf_write_addr   <= '0;
            rf_write_value  <= '0;
            retire_valid    <= 1'b0;
            retire_addr     <= '0;
        end else begin
            rf_write_enable <= dec_hit;
            retire_valid    <= dec_hit;
            if (grant_any) begin
                rf_write_addr  <= g_addr;
                rf_write_value <= g_value;
                retire_addr    <= g_addr;
            end
        end
    end

    // x0 is never touched here, so its counter stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                cnt[r] <= '0;
            end
            error <= 1'b0;
        end else if (!same_reg) begin
            if (inc_hit) begin
                if (cnt[issue_rd] == CNT_MAX) begin
                    error <= 1'b1;
                end else begin
                    cnt[issue_rd] <= cnt[issue_rd] + 1'b1;
                end
            end
            if (dec_hit) begin
                if (cnt[g_addr] == '0) begin
                    error <= 1'b1;
                end else begin
                    cnt[g_addr] <= cnt[g_addr] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        reg_counters = '0;
        for (int r = 0; r < 32; r++) begin
            reg_counters[r*COUNTER_WIDTH +: COUNTER_WIDTH] = cnt[r];
        end
    end

endmodule
